// File: rtl/k_alu_arbiter.sv
// Round-robin share of one combinational ALU: grant -> EXEC settle -> registered RESP (rsp_valid 2 cycles after req_ready).
// Response holds until rsp_ready with no new grants meanwhile; K_ALU_ARB_ZFLAG_EN adds the registered rsp_zero flag.
module k_alu_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int SW   = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  input  logic [NREQ*SW-1:0] req_sel,
  output logic [DW-1:0]      alu_a,
  output logic [DW-1:0]      alu_b,
  output logic [SW-1:0]      alu_sel,
  input  logic [DW-1:0]      alu_res,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_data,
  output logic               busy
`ifdef K_ALU_ARB_ZFLAG_EN
  ,
  output logic               rsp_zero
`endif
);

  if (NREQ < 2 || (1 << IDW) < NREQ) begin : g_bad_cfg
    $error("k_alu_arbiter: NREQ must be at least 2 and representable in IDW bits");
  end

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [DW-1:0]  op_a_q, op_a_d;
  logic [DW-1:0]  op_b_q, op_b_d;
  logic [SW-1:0]  op_sel_q, op_sel_d;
  logic [DW-1:0]  rsp_data_q, rsp_data_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
`ifdef K_ALU_ARB_ZFLAG_EN
  logic           rsp_zero_q, rsp_zero_d;
`endif

  logic           found;
  int             gnt_i;
  int             idx;
  logic [NREQ-1:0] grant_oh;

  // Search starts just after the last winner and wraps, so every requester is reached within NREQ grants.
  always_comb begin
    found = 1'b0;
    gnt_i = 0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt_i = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_id_d   = gnt_id_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_sel_d   = op_sel_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
`ifdef K_ALU_ARB_ZFLAG_EN
    rsp_zero_d = rsp_zero_q;
`endif
    grant_oh   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_oh[gnt_i] = 1'b1;
          op_a_d          = req_a[gnt_i*DW +: DW];
          op_b_d          = req_b[gnt_i*DW +: DW];
          op_sel_d        = req_sel[gnt_i*SW +: SW];
          gnt_id_d        = gnt_i[IDW-1:0];
          last_d          = gnt_i[IDW-1:0];
          state_d         = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_data_d = alu_res;
        rsp_id_d   = gnt_id_q;
`ifdef K_ALU_ARB_ZFLAG_EN
        rsp_zero_d = (alu_res == '0);
`endif
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_q     <= IDW'(NREQ-1);
      gnt_id_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_sel_q   <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
`ifdef K_ALU_ARB_ZFLAG_EN
      rsp_zero_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_id_q   <= gnt_id_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_sel_q   <= op_sel_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
`ifdef K_ALU_ARB_ZFLAG_EN
      rsp_zero_q <= rsp_zero_d;
`endif
    end
  end

  // Grant is combinational, so it is masked while reset is asserted to keep every output at zero.
  assign req_ready = rst_n ? grant_oh : '0;
  assign alu_a     = op_a_q;
  assign alu_b     = op_b_q;
  assign alu_sel   = op_sel_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != S_IDLE);
`ifdef K_ALU_ARB_ZFLAG_EN
  assign rsp_zero  = rsp_zero_q;
`endif

endmodule

// File: tb/tb_k_alu_arbiter.sv
// Bench for k_alu_arbiter: directed scenarios plus random requesters against an operation-level reference model.
module tb_k_alu_arbiter;
  localparam int NREQ = 4;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [127:0]  req_a;
  logic [127:0]  req_b;
  logic [15:0]   req_sel;
  logic [31:0]   alu_a, alu_b, alu_res;
  logic [3:0]    alu_sel;
  logic          rsp_valid, rsp_ready, busy;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_data;
`ifdef K_ALU_ARB_ZFLAG_EN
  logic          rsp_zero;
`endif

  k_alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
`ifdef K_ALU_ARB_ZFLAG_EN
    , .rsp_zero(rsp_zero)
`endif
  );

  // K_ALU_32 reference: 0 add, 1 sub, 2 and, 3 or, 4 xor, else pass A.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  assign alu_res = alu_fn(alu_a, alu_b, alu_sel);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Operation-level model: one outstanding op, its age in cycles since acceptance, and the last winner.
  int          m_last;
  bit          m_open;
  int          m_age;
  logic [31:0] m_a, m_b, m_data;
  logic [3:0]  m_sel;
  int          m_id;
  int          last_grant;
  int          cyc;
  int          gnt_log[$];
  int          gnt_cyc[$];

  // Winner = valid requester at the smallest circular distance after the previous winner.
  function automatic int rr_pick(input logic [3:0] v, input int last);
    int best, best_d, d;
    best   = -1;
    best_d = NREQ + 1;
    for (int i = 0; i < NREQ; i++) begin
      d = (i - last - 1 + 2*NREQ) % NREQ;
      if (v[i] && d < best_d) begin
        best   = i;
        best_d = d;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_open = 0; m_age = 0; m_last = NREQ-1; last_grant = -1;
  endtask

  task automatic step();
    int g;
    logic [3:0] exp_rdy;
    @(negedge clk);
    g = m_open ? -1 : rr_pick(req_valid, m_last);
    exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk("req_ready", req_ready, exp_rdy);
    chk("busy", busy, m_open);
    chk("rsp_valid", rsp_valid, m_open && m_age >= 1);
    if (m_open) begin
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_sel", alu_sel, m_sel);
    end
    if (m_open && m_age >= 1) begin
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_id", rsp_id, m_id);
`ifdef K_ALU_ARB_ZFLAG_EN
      chk("rsp_zero", rsp_zero, m_data == 32'd0);
`endif
    end
    @(posedge clk); #1;
    cyc++;
    last_grant = g;
    if (g >= 0) begin
      m_open = 1; m_age = 0; m_last = g; m_id = g;
      m_a    = req_a[g*32 +: 32];
      m_b    = req_b[g*32 +: 32];
      m_sel  = req_sel[g*4 +: 4];
      m_data = alu_fn(m_a, m_b, m_sel);
      gnt_log.push_back(g);
      gnt_cyc.push_back(cyc);
    end else if (m_open) begin
      if (m_age >= 1 && rsp_ready) m_open = 0;
      else m_age++;
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_sel[i*4 +: 4] = s;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Requesters hold valid and fields until granted; they may withdraw, but never change a pending op.
  task automatic rand_drive();
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && last_grant != i) begin
        if ($urandom_range(9) == 0) req_valid[i] = 1'b0;
      end else begin
        req_valid[i] = ($urandom_range(1) == 1);
        if ($urandom_range(3) == 0) set_req(i, 32'($urandom_range(20)), 32'($urandom_range(20)), 4'($urandom_range(5)));
        else set_req(i, $urandom, $urandom, 4'($urandom_range(5)));
      end
    end
    rsp_ready = ($urandom_range(3) != 0);
  endtask

  logic [31:0] held_data;
  logic [1:0]  held_id;

  initial begin
    req_a = '0; req_b = '0; req_sel = '0;
    cyc = 0;
    do_reset();
    // reset state was observed just before release; re-enter reset to check values
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 4'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_sel", alu_sel, 4'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_id", rsp_id, 2'd0);
    do_reset();

    // single op
    set_req(0, 32'd48, 32'd78, 4'd0);
    req_valid = 4'b0001;
    step();
    chk("single_gnt", last_grant, 0);
    req_valid = 4'b0000;
    step();
    chk("single_rsp_valid", rsp_valid, 1'b1);
    chk("single_data", rsp_data, 32'd126);
    chk("single_id", rsp_id, 2'd0);
    step();
    step();

    // contention
    do_reset();
    gnt_log.delete(); gnt_cyc.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 1), 32'(10 * i), 4'd0);
    req_valid = 4'b1111;
    repeat (13) step();
    chk("cont_count", gnt_log.size() >= 5, 1'b1);
    for (int k = 0; k < 5 && k < gnt_log.size(); k++) chk("cont_order", gnt_log[k], k % NREQ);
    for (int k = 0; k + 1 < 5 && k + 1 < gnt_cyc.size(); k++) chk("cont_spacing", gnt_cyc[k+1] - gnt_cyc[k], 3);

    // backpressure
    do_reset();
    set_req(0, 32'd100, 32'd23, 4'd1);
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0100;
    set_req(2, 32'd7, 32'd9, 4'd0);
    rsp_ready = 1'b0;
    step();
    held_data = rsp_data;
    held_id   = rsp_id;
    chk("bp_data", held_data, 32'd77);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_no_gnt", last_grant, -1);
      chk("bp_data_stable", rsp_data, held_data);
      chk("bp_id_stable", rsp_id, held_id);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_accept_no_gnt", last_grant, -1);
    step();
    chk("bp_gnt2", last_grant, 2);

    // pointer wrap: last winner 2, then 3, then {1,3} -> 1 before 3
    req_valid = 4'b0000;
    step(); step();
    set_req(3, 32'd11, 32'd4, 4'd0);
    req_valid = 4'b1000;
    step();
    chk("wrap_gnt3", last_grant, 3);
    req_valid = 4'b0000;
    step(); step();
    set_req(1, 32'd5, 32'd6, 4'd3);
    req_valid = 4'b1010;
    step();
    chk("wrap_first", last_grant, 1);
    req_valid = 4'b1000;
    step(); step();
    step();
    chk("wrap_second", last_grant, 3);
    req_valid = 4'b0000;
    step(); step();

    // async reset during EXEC
    set_req(0, 32'd9, 32'd3, 4'd0);
    req_valid = 4'b0001;
    step();
    req_valid = 4'b1010;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 1'b0);
    chk("ar_rsp_valid", rsp_valid, 1'b0);
    chk("ar_req_ready", req_ready, 4'b0);
    chk("ar_alu_a", alu_a, 32'd0);
    chk("ar_alu_b", alu_b, 32'd0);
    chk("ar_rsp_data", rsp_data, 32'd0);
    chk("ar_rsp_id", rsp_id, 2'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("ar_hold_rsp_valid", rsp_valid, 1'b0);
    end
    rst_n = 1'b1;
    model_reset();
    step();
    chk("ar_first_gnt", last_grant, 1);
    req_valid = 4'b1000;
    step(); step(); step();
    req_valid = 4'b0000;
    step(); step(); step();

`ifdef K_ALU_ARB_ZFLAG_EN
    set_req(0, 32'd5, 32'd5, 4'd1);
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    step();
    chk("zf_data", rsp_data, 32'd0);
    chk("zf_zero", rsp_zero, 1'b1);
    step(); step();
    set_req(0, 32'd48, 32'd78, 4'd0);
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    step();
    chk("zf_data2", rsp_data, 32'd126);
    chk("zf_nonzero", rsp_zero, 1'b0);
    step(); step();
`endif

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rand_drive();
      step();
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
